egress_frame_serializer: RTL and testbench

//   Per-port egress stage between a port's output FIFO and the physical tx line of the L2 switch.
//   - Pops one frame through a valid/ready handshake.
//   - Checks its start-of-frame delimiter (SFD) and drops malformed frames.
//   - Shifts the frame out MSB-first, one bit per clock, then holds an inter-frame gap (IFG).
//   - Keeps sent/dropped frame counters for debug.

---
 rtl/l2_switch_pkg.sv | 23 ++
 rtl/egress_frame_serializer_sat_counter.sv | 23 ++
 rtl/egress_frame_serializer.sv | 166 ++++++++++++++++
 tb/tb_egress_frame_serializer.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/l2_switch_pkg.sv
// Shared L2 switch definitions: frame field layout and egress serializer state encoding.
// Related build option: TX_PARITY_EN (adds one even-parity bit after each frame).
package l2_switch_pkg;

  localparam int unsigned FRAME_DEPTH    = 16;
  localparam int unsigned SFD_WIDTH      = 4;
  localparam logic [SFD_WIDTH-1:0] SFD_PATTERN = 4'b1010;
  localparam int unsigned DEST_MSB       = 11;
  localparam int unsigned DEST_LSB       = 8;
  localparam int unsigned SRC_MSB        = 7;
  localparam int unsigned SRC_LSB        = 4;
  localparam logic [3:0]  BROADCAST_ADDR = 4'hF;
  localparam int unsigned IFG_CYCLES_DEF = 2;
  localparam int unsigned CNT_WIDTH_DEF  = 8;

  // Serializer state encoding, kept as plain constants for legacy tools
  localparam int unsigned STATE_W  = 2;
  localparam logic [1:0]  S_IDLE   = 2'd0;
  localparam logic [1:0]  S_SHIFT  = 2'd1;
  localparam logic [1:0]  S_PARITY = 2'd2;
  localparam logic [1:0]  S_GAP    = 2'd3;

endpackage

// File: rtl/egress_frame_serializer_sat_counter.sv
// Saturating up-counter used for the egress debug statistics.
module sat_counter #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_inc,
  output logic [WIDTH-1:0] o_cnt
);

  logic [WIDTH-1:0] r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_inc && (r_cnt != '1)) begin
      r_cnt <= r_cnt + WIDTH'(1);
    end
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/egress_frame_serializer.sv
// Egress serializer: pops a frame, checks its SFD, shifts it out MSB-first, then holds the IFG.
// Build option: `define TX_PARITY_EN appends one even-parity bit after the frame bits.
module egress_frame_serializer #(
  parameter int unsigned DEPTH      = l2_switch_pkg::FRAME_DEPTH,
  parameter int unsigned SFD_WIDTH  = l2_switch_pkg::SFD_WIDTH,
  parameter logic [SFD_WIDTH-1:0] SFD_PATTERN = SFD_WIDTH'(l2_switch_pkg::SFD_PATTERN),
  parameter int unsigned IFG_CYCLES = l2_switch_pkg::IFG_CYCLES_DEF,
  parameter int unsigned CNT_WIDTH  = l2_switch_pkg::CNT_WIDTH_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 abort,
  input  logic [DEPTH-1:0]     frame_in,
  input  logic                 frame_valid,
  output logic                 frame_ready,
  output logic                 tx_bit,
  output logic                 tx_busy,
  output logic [CNT_WIDTH-1:0] sent_cnt,
  output logic [CNT_WIDTH-1:0] drop_cnt
);

  import l2_switch_pkg::*;

  localparam int unsigned BIT_W     = $clog2(DEPTH + 1);
  localparam int unsigned GAP_RAW_W = $clog2(IFG_CYCLES + 1);
  localparam int unsigned GAP_W     = (GAP_RAW_W < 1) ? 1 : GAP_RAW_W;
  localparam logic [1:0]  S_AFTER   = (IFG_CYCLES == 0) ? S_IDLE : S_GAP;

  logic [STATE_W-1:0] r_state;
  logic [DEPTH-1:0]   r_shreg;
  logic [BIT_W-1:0]   r_bit_cnt;
  logic [GAP_W-1:0]   r_gap_cnt;
  logic               r_tx_bit;
  logic               r_tx_busy;

  logic [STATE_W-1:0] w_state_nxt;
  logic [DEPTH-1:0]   w_shreg_nxt;
  logic [BIT_W-1:0]   w_bit_cnt_nxt;
  logic [GAP_W-1:0]   w_gap_cnt_nxt;
  logic               w_tx_bit_nxt;
  logic               w_accept;
  logic               w_sfd_ok;
  logic               w_last_bit;
  logic               w_sent_inc;
  logic               w_drop_inc;

`ifdef TX_PARITY_EN
  logic r_parity;
  logic w_parity_nxt;
`endif

  assign frame_ready = (r_state == S_IDLE) && !rst && !abort;
  assign w_accept    = frame_valid && frame_ready;
  assign w_sfd_ok    = (frame_in[DEPTH-1 -: SFD_WIDTH] == SFD_PATTERN);
  assign w_last_bit  = (r_bit_cnt == BIT_W'(DEPTH - 1));

  // State register and all registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_shreg   <= '0;
      r_bit_cnt <= '0;
      r_gap_cnt <= '0;
      r_tx_bit  <= 1'b0;
      r_tx_busy <= 1'b0;
`ifdef TX_PARITY_EN
      r_parity  <= 1'b0;
`endif
    end else begin
      r_state   <= w_state_nxt;
      r_shreg   <= w_shreg_nxt;
      r_bit_cnt <= w_bit_cnt_nxt;
      r_gap_cnt <= w_gap_cnt_nxt;
      r_tx_bit  <= w_tx_bit_nxt;
      r_tx_busy <= (w_state_nxt != S_IDLE);
`ifdef TX_PARITY_EN
      r_parity  <= w_parity_nxt;
`endif
    end
  end

  // The MSB is driven at the accept edge, so SHIFT lasts exactly DEPTH cycles
  always_comb begin
    w_state_nxt   = r_state;
    w_shreg_nxt   = r_shreg;
    w_bit_cnt_nxt = r_bit_cnt;
    w_gap_cnt_nxt = r_gap_cnt;
    w_tx_bit_nxt  = 1'b0;
    w_sent_inc    = 1'b0;
    w_drop_inc    = 1'b0;
`ifdef TX_PARITY_EN
    w_parity_nxt  = r_parity;
`endif
    if (abort) begin
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            if (w_sfd_ok) begin
              w_state_nxt   = S_SHIFT;
              w_shreg_nxt   = frame_in;
              w_bit_cnt_nxt = '0;
              w_tx_bit_nxt  = frame_in[DEPTH-1];
`ifdef TX_PARITY_EN
              w_parity_nxt  = ^frame_in;
`endif
            end else begin
              w_drop_inc = 1'b1;
            end
          end
        end
        S_SHIFT: begin
          w_shreg_nxt   = r_shreg << 1;
          w_bit_cnt_nxt = r_bit_cnt + BIT_W'(1);
          if (w_last_bit) begin
`ifdef TX_PARITY_EN
            w_state_nxt   = S_PARITY;
            w_tx_bit_nxt  = r_parity;
`else
            w_state_nxt   = S_AFTER;
            w_gap_cnt_nxt = '0;
            w_sent_inc    = 1'b1;
`endif
          end else begin
            w_tx_bit_nxt = r_shreg[DEPTH-2];
          end
        end
`ifdef TX_PARITY_EN
        S_PARITY: begin
          w_state_nxt   = S_AFTER;
          w_gap_cnt_nxt = '0;
          w_sent_inc    = 1'b1;
        end
`endif
        S_GAP: begin
          w_gap_cnt_nxt = r_gap_cnt + GAP_W'(1);
          if (r_gap_cnt == GAP_W'(IFG_CYCLES - 1)) begin
            w_state_nxt = S_IDLE;
          end
        end
        default: begin
          w_state_nxt = S_IDLE;
        end
      endcase
    end
  end

  sat_counter #(.WIDTH(CNT_WIDTH)) u_sent_cnt (
    .clk   (clk),
    .rst   (rst),
    .i_inc (w_sent_inc),
    .o_cnt (sent_cnt)
  );

  sat_counter #(.WIDTH(CNT_WIDTH)) u_drop_cnt (
    .clk   (clk),
    .rst   (rst),
    .i_inc (w_drop_inc),
    .o_cnt (drop_cnt)
  );

  assign tx_bit  = r_tx_bit;
  assign tx_busy = r_tx_busy;

endmodule

// File: tb/tb_egress_frame_serializer.sv
// Directed bench for egress_frame_serializer: vector table plus hand-written abort/reset/saturation sequences.
module tb_egress_frame_serializer;

  localparam int unsigned DEPTH = 16;
  localparam int unsigned IFG   = 2;
`ifdef TX_PARITY_EN
  localparam int unsigned P = 1;
`else
  localparam int unsigned P = 0;
`endif
  localparam int unsigned PERIOD = 1 + DEPTH + P + IFG;

  logic        clk;
  logic        rst;
  logic        abort;
  logic [15:0] frame_in;
  logic        frame_valid;
  logic        frame_ready;
  logic        tx_bit;
  logic        tx_busy;
  logic [7:0]  sent_cnt;
  logic [7:0]  drop_cnt;

  int n_vec;
  int n_err;
  logic [7:0] exp_sent;
  logic [7:0] exp_drop;

  typedef struct {
    logic [15:0] frame;
    logic        good;
    logic [15:0] bits;
    logic        par;
  } vec_t;

  vec_t vecs[7];

  egress_frame_serializer dut (
    .clk         (clk),
    .rst         (rst),
    .abort       (abort),
    .frame_in    (frame_in),
    .frame_valid (frame_valid),
    .frame_ready (frame_ready),
    .tx_bit      (tx_bit),
    .tx_busy     (tx_busy),
    .sent_cnt    (sent_cnt),
    .drop_cnt    (drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk1(input string name, input logic act, input logic exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0b expected %0b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // Starts and ends at a negedge with the DUT idle
  task automatic run_vec(input vec_t v);
    frame_in    = v.frame;
    frame_valid = 1'b1;
    #1;
    chk1("ready_idle", frame_ready, 1'b1);
    @(posedge clk);
    #1 frame_valid = 1'b0;
    @(negedge clk);
    if (v.good) begin
      for (int k = 0; k < 16; k++) begin
        if (k > 0) @(negedge clk);
        chk1("tx_data", tx_bit, v.bits[15-k]);
        chk1("busy_shift", tx_busy, 1'b1);
        chk1("ready_shift", frame_ready, 1'b0);
      end
`ifdef TX_PARITY_EN
      @(negedge clk);
      chk1("tx_parity", tx_bit, v.par);
      chk1("busy_parity", tx_busy, 1'b1);
`endif
      for (int g = 0; g < int'(IFG); g++) begin
        @(negedge clk);
        chk1("tx_gap", tx_bit, 1'b0);
        chk1("busy_gap", tx_busy, 1'b1);
        chk1("ready_gap", frame_ready, 1'b0);
      end
      @(negedge clk);
      exp_sent = sat_inc(exp_sent);
      chk1("busy_end", tx_busy, 1'b0);
      chk1("ready_end", frame_ready, 1'b1);
      chk8("sent_cnt", sent_cnt, exp_sent);
      chk8("drop_cnt_good", drop_cnt, exp_drop);
    end else begin
      exp_drop = sat_inc(exp_drop);
      chk1("tx_bad", tx_bit, 1'b0);
      chk1("busy_bad", tx_busy, 1'b0);
      chk1("ready_bad", frame_ready, 1'b1);
      chk8("drop_cnt", drop_cnt, exp_drop);
      chk8("sent_cnt_bad", sent_cnt, exp_sent);
    end
  endtask

  task automatic quick_send(input logic [15:0] f);
    frame_in    = f;
    frame_valid = 1'b1;
    @(posedge clk);
    #1 frame_valid = 1'b0;
    repeat (PERIOD) @(negedge clk);
  endtask

  initial begin
    logic [15:0] fa;
    logic [15:0] fb;
    n_vec = 0;
    n_err = 0;
    exp_sent = 8'd0;
    exp_drop = 8'd0;
    vecs[0] = '{16'hA5C3, 1'b1, 16'b1010_0101_1100_0011, 1'b0};
    vecs[1] = '{16'h5123, 1'b0, 16'h0000, 1'b0};
    vecs[2] = '{16'hAFFF, 1'b1, 16'b1010_1111_1111_1111, 1'b0};
    vecs[3] = '{16'hA001, 1'b1, 16'b1010_0000_0000_0001, 1'b1};
    vecs[4] = '{16'h0000, 1'b0, 16'h0000, 1'b0};
    vecs[5] = '{16'hB123, 1'b0, 16'h0000, 1'b0};
    vecs[6] = '{16'hA000, 1'b1, 16'b1010_0000_0000_0000, 1'b0};

    rst = 1'b1;
    abort = 1'b0;
    frame_in = 16'h0;
    frame_valid = 1'b0;
    #1;
    chk1("rst_tx", tx_bit, 1'b0);
    chk1("rst_busy", tx_busy, 1'b0);
    chk1("rst_ready", frame_ready, 1'b0);
    chk8("rst_sent", sent_cnt, 8'd0);
    chk8("rst_drop", drop_cnt, 8'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;

    // Idle with no valid frame
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk1("idle_tx", tx_bit, 1'b0);
      chk1("idle_ready", frame_ready, 1'b1);
      chk1("idle_busy", tx_busy, 1'b0);
      chk8("idle_sent", sent_cnt, 8'd0);
    end

    for (int i = 0; i < 7; i++) run_vec(vecs[i]);

    // Back-to-back: valid held high through the first frame
    fa = 16'hA123;
    fb = 16'hA456;
    frame_in = fa;
    frame_valid = 1'b1;
    @(posedge clk);
    #1 frame_in = fb;
    @(negedge clk);
    for (int k = 0; k < int'(PERIOD) + 16; k++) begin
      if (k > 0) @(negedge clk);
      if (k < 16) chk1("b2b_tx_a", tx_bit, fa[15-k]);
      if (k < int'(PERIOD) - 1) chk1("b2b_ready_low", frame_ready, 1'b0);
      if (k == int'(PERIOD) - 1) begin
        chk1("b2b_ready_high", frame_ready, 1'b1);
        chk1("b2b_tx_idle", tx_bit, 1'b0);
      end
      if (k >= int'(PERIOD)) chk1("b2b_tx_b", tx_bit, fb[15-(k-int'(PERIOD))]);
      if (k == int'(PERIOD)) frame_valid = 1'b0;
    end
    repeat (PERIOD - 1 - 15) @(negedge clk);
    exp_sent = sat_inc(sat_inc(exp_sent));
    chk8("b2b_sent", sent_cnt, exp_sent);
    chk1("b2b_busy_end", tx_busy, 1'b0);

    // Abort at bit 7 of AFFF
    frame_in = 16'hAFFF;
    frame_valid = 1'b1;
    @(posedge clk);
    #1 frame_valid = 1'b0;
    repeat (9) @(negedge clk);
    chk1("abort_bit7", tx_bit, 1'b1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    #1;
    chk1("abort_tx", tx_bit, 1'b0);
    chk1("abort_busy", tx_busy, 1'b0);
    chk1("abort_ready", frame_ready, 1'b1);
    chk8("abort_sent", sent_cnt, exp_sent);
    run_vec(vecs[0]);

    // Abort on the final data bit suppresses the sent count
    frame_in = 16'hA5C3;
    frame_valid = 1'b1;
    @(posedge clk);
    #1 frame_valid = 1'b0;
    repeat (16) @(negedge clk);
    chk1("abort_last_bit", tx_bit, 1'b1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    #1;
    chk1("abort_last_tx", tx_bit, 1'b0);
    chk8("abort_last_sent", sent_cnt, exp_sent);

    // Abort beats a same-cycle accept
    frame_in = 16'hA5C3;
    frame_valid = 1'b1;
    abort = 1'b1;
    #1;
    chk1("abort_idle_ready", frame_ready, 1'b0);
    @(negedge clk);
    frame_valid = 1'b0;
    abort = 1'b0;
    #1;
    chk1("abort_idle_busy", tx_busy, 1'b0);
    chk8("abort_idle_drop", drop_cnt, exp_drop);

    // Asynchronous reset in mid-SHIFT
    frame_in = 16'hA5C3;
    frame_valid = 1'b1;
    @(posedge clk);
    #1 frame_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk1("pre_rst_tx", tx_bit, 1'b1);
    #2 rst = 1'b1;
    #1;
    chk1("async_rst_tx", tx_bit, 1'b0);
    chk1("async_rst_busy", tx_busy, 1'b0);
    chk8("async_rst_sent", sent_cnt, 8'd0);
    chk8("async_rst_drop", drop_cnt, 8'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    exp_sent = 8'd0;
    exp_drop = 8'd0;
    #1;
    run_vec(vecs[3]);

    // Drop counter saturation with a bad frame held valid
    frame_in = 16'h5123;
    frame_valid = 1'b1;
    repeat (300) @(posedge clk);
    @(negedge clk);
    frame_valid = 1'b0;
    chk8("drop_sat", drop_cnt, 8'hFF);
    chk1("drop_sat_tx", tx_bit, 1'b0);

    // Sent counter saturation
    for (int i = 0; i < 260; i++) begin
      quick_send(16'hA5C3);
      exp_sent = sat_inc(exp_sent);
    end
    chk8("sent_sat", sent_cnt, exp_sent);
    chk8("sent_sat_ff", sent_cnt, 8'hFF);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
